// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_cmd_ctrl_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int FUN_WIDTH  = 4;
   localparam int RES_WIDTH  = 2 * DATA_WIDTH;

   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_A,
      ST_GET_B,
      ST_GET_FUN,
      ST_EXEC,
      ST_WAIT_RES,
      ST_SEND_LO,
      ST_SEND_HI
   } state_t;

   // Select the low or high byte of an ALU result for transmission.
   function automatic logic [DATA_WIDTH-1:0] res_byte(input logic [RES_WIDTH-1:0] r,
                                                      input logic hi);
      return hi ? r[RES_WIDTH-1:DATA_WIDTH] : r[DATA_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Bundle of RX, ALU and TX signals around the command sequencer.
// slave = the sequencer, master = its environment (UART + ALU).
interface alu_cmd_ctrl_if;
   import alu_cmd_ctrl_pkg::*;

   logic [DATA_WIDTH-1:0] RX_P_DATA;
   logic                  RX_D_VLD;
   logic [DATA_WIDTH-1:0] ALU_A;
   logic [DATA_WIDTH-1:0] ALU_B;
   logic [FUN_WIDTH-1:0]  ALU_FUN;
   logic                  ALU_EN;
   logic [RES_WIDTH-1:0]  ALU_OUT;
   logic                  OUT_VALID;
   logic [DATA_WIDTH-1:0] TX_P_DATA;
   logic                  TX_D_VLD;
   logic                  TX_BUSY;
   logic                  CMD_ERR;

   modport slave (
      input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_BUSY,
      output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
   );

   modport master (
      output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_BUSY,
      input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
   );

endinterface

// File: rtl/alu_cmd_ctrl_res_timer.sv
// Result-wait timer: counts enabled cycles, saturates at RES_TIMEOUT and
// flags expiry once the count has reached the limit.
module alu_res_timer #(
   parameter int RES_TIMEOUT = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   input  logic clr,
   output logic expired
);

   localparam int TW = $clog2(RES_TIMEOUT + 1);
   localparam logic [TW-1:0] LIMIT = TW'(RES_TIMEOUT);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // Next count: clear has priority, otherwise count up until saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/alu_cmd_ctrl.sv
// ALU command sequencer: parses RX frames into operands/function, pulses
// ALU_EN, waits for the result (with timeout) and returns it LSB first.
module alu_cmd_ctrl
   import alu_cmd_ctrl_pkg::*;
#(
   parameter int RES_TIMEOUT = 8
) (
   input  logic           CLK,
   input  logic           RST,
   alu_cmd_ctrl_if.slave  bus
);

   state_t                state_q;
   logic [DATA_WIDTH-1:0] alu_a_q;
   logic [DATA_WIDTH-1:0] alu_b_q;
   logic [FUN_WIDTH-1:0]  alu_fun_q;
   logic                  alu_en_q;
   logic [RES_WIDTH-1:0]  result_q;
   logic [DATA_WIDTH-1:0] tx_data_q;
   logic                  tx_vld_q;
   logic                  cmd_err_q;

   logic tmr_en;
   logic tmr_clr;
   logic tmr_expired;
   logic rx_busy_state;

   // The timer runs from the ALU_EN cycle so the first WAIT_RES cycle reads 1;
   // it is cleared whenever WAIT_RES is being left or not active.
   assign tmr_en  = (state_q == ST_EXEC) || (state_q == ST_WAIT_RES);
   assign tmr_clr = !tmr_en ||
                    ((state_q == ST_WAIT_RES) && (bus.OUT_VALID || tmr_expired));

   // States in which an incoming RX byte cannot be consumed.
   assign rx_busy_state = (state_q == ST_EXEC) || (state_q == ST_WAIT_RES) ||
                          (state_q == ST_SEND_LO) || (state_q == ST_SEND_HI);

   alu_res_timer #(
      .RES_TIMEOUT (RES_TIMEOUT)
   ) u_timer (
      .CLK     (CLK),
      .RST     (RST),
      .en      (tmr_en),
      .clr     (tmr_clr),
      .expired (tmr_expired)
   );

   // Frame parser, result capture and TX handshake with registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_fun_q <= '0;
         alu_en_q  <= 1'b0;
         result_q  <= '0;
         tx_data_q <= '0;
         tx_vld_q  <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         alu_en_q  <= 1'b0;
         cmd_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.RX_D_VLD) begin
                  if (bus.RX_P_DATA == CMD_ALU_OP) begin
                     state_q <= ST_GET_A;
                  end else if (bus.RX_P_DATA == CMD_ALU_NOP) begin
                     state_q <= ST_GET_FUN;
                  end else begin
                     cmd_err_q <= 1'b1;
                  end
               end
            end
            ST_GET_A: begin
               if (bus.RX_D_VLD) begin
                  alu_a_q <= bus.RX_P_DATA;
                  state_q <= ST_GET_B;
               end
            end
            ST_GET_B: begin
               if (bus.RX_D_VLD) begin
                  alu_b_q <= bus.RX_P_DATA;
                  state_q <= ST_GET_FUN;
               end
            end
            ST_GET_FUN: begin
               if (bus.RX_D_VLD) begin
                  alu_fun_q <= bus.RX_P_DATA[FUN_WIDTH-1:0];
                  alu_en_q  <= 1'b1;
                  state_q   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               state_q <= ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
               if (bus.OUT_VALID) begin
                  result_q <= bus.ALU_OUT;
                  state_q  <= ST_SEND_LO;
               end else if (tmr_expired) begin
                  cmd_err_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            ST_SEND_LO, ST_SEND_HI: begin
               if (!tx_vld_q) begin
                  if (!bus.TX_BUSY) begin
                     tx_vld_q  <= 1'b1;
                     tx_data_q <= res_byte(result_q, state_q == ST_SEND_HI);
                  end
               end else if (bus.TX_BUSY) begin
                  tx_vld_q <= 1'b0;
                  state_q  <= (state_q == ST_SEND_LO) ? ST_SEND_HI : ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
         if (bus.RX_D_VLD && rx_busy_state) begin
            cmd_err_q <= 1'b1;
         end
      end
   end

   assign bus.ALU_A     = alu_a_q;
   assign bus.ALU_B     = alu_b_q;
   assign bus.ALU_FUN   = alu_fun_q;
   assign bus.ALU_EN    = alu_en_q;
   assign bus.TX_P_DATA = tx_data_q;
   assign bus.TX_D_VLD  = tx_vld_q;
   assign bus.CMD_ERR   = cmd_err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl: stimulus pushes expected ALU_EN,
// CMD_ERR and TX events; monitor, ALU model and TX model pop and compare.
module tb_alu_cmd_ctrl;
   import alu_cmd_ctrl_pkg::*;

   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_cmd_ctrl_if bus ();

   alu_cmd_ctrl #(.RES_TIMEOUT(TMO)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] fun;
      int         cyc;
   } en_exp_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   en_exp_t    exp_en_q[$];
   logic [7:0] exp_tx_q[$];
   int         exp_err_q[$];

   logic [7:0] m_a = 8'h00;
   logic [7:0] m_b = 8'h00;
   int         alu_lat = 2;
   logic       busy_tx = 1'b0;
   logic       busy_bp = 1'b0;

   assign bus.TX_BUSY = busy_tx | busy_bp;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference ALU behaviour, shared by the ALU stand-in and the expectations.
   function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] f);
      case (f)
         4'd0:    return 16'(a) + 16'(b);
         4'd1:    return 16'(a) - 16'(b);
         4'd2:    return 16'(a) * 16'(b);
         4'd3:    return (b == 8'h00) ? 16'hFFFF : 16'(a / b);
         4'd4:    return 16'(a & b);
         4'd5:    return 16'(a | b);
         4'd6:    return 16'(a ^ b);
         default: return {a, b};
      endcase
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic fail_evt(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got event, required none (cycle %0d)", nm, cyc);
   endtask

   // ---------------- ALU stand-in ----------------
   int         rsp_lat;
   logic [15:0] rsp_val;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.ALU_EN) begin
            rsp_lat = alu_lat;
            rsp_val = alu_ref(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
            if (rsp_lat > 0) begin
               repeat (rsp_lat) @(posedge clk);
               #1 bus.ALU_OUT = rsp_val;
               bus.OUT_VALID = 1'b1;
               @(posedge clk);
               #1 bus.OUT_VALID = 1'b0;
            end
         end
      end
   end

   // ---------------- TX stand-in ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.TX_D_VLD) begin
            if (exp_tx_q.size() == 0) begin
               fail_evt("tx_unexpected");
            end else begin
               check("tx_byte", bus.TX_P_DATA, exp_tx_q.pop_front());
            end
            $display("TX byte %02h at cycle %0d", bus.TX_P_DATA, cyc);
            @(posedge clk);
            #1 busy_tx = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 busy_tx = 1'b0;
         end
      end
   end

   // ---------------- Monitor ----------------
   logic       vld_p  = 1'b0;
   logic       busy_p = 1'b0;
   logic       en_p   = 1'b0;
   logic [7:0] data_p = 8'h00;
   en_exp_t    mon_e;
   int         mon_c;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.ALU_EN) begin
               check("alu_en_one_cycle", en_p, 0);
               if (exp_en_q.size() == 0) begin
                  fail_evt("alu_en_unexpected");
               end else begin
                  mon_e = exp_en_q.pop_front();
                  check("alu_a", bus.ALU_A, mon_e.a);
                  check("alu_b", bus.ALU_B, mon_e.b);
                  check("alu_fun", bus.ALU_FUN, mon_e.fun);
                  check("alu_en_cycle", cyc, mon_e.cyc);
                  $display("ALU_EN A=%02h B=%02h FUN=%0h at cycle %0d",
                           bus.ALU_A, bus.ALU_B, bus.ALU_FUN, cyc);
               end
            end
            if (bus.CMD_ERR) begin
               if (exp_err_q.size() == 0) begin
                  fail_evt("cmd_err_unexpected");
               end else begin
                  mon_c = exp_err_q.pop_front();
                  check("cmd_err_cycle", cyc, mon_c);
                  $display("CMD_ERR at cycle %0d", cyc);
               end
            end
            if (bus.TX_D_VLD && !vld_p) check("tx_vld_rise_while_busy", busy_p, 0);
            if (bus.TX_D_VLD && vld_p)  check("tx_data_stable", bus.TX_P_DATA, data_p);
         end
         vld_p  = bus.TX_D_VLD;
         busy_p = bus.TX_BUSY;
         en_p   = bus.ALU_EN;
         data_p = bus.TX_P_DATA;
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b, output int s);
      @(posedge clk);
      #1 bus.RX_P_DATA = b;
      bus.RX_D_VLD = 1'b1;
      s = cyc;
      @(posedge clk);
      #1 bus.RX_D_VLD = 1'b0;
   endtask

   // Expectations after the FUN byte strobe at cycle s: ALU_EN at s+1,
   // result bytes if the ALU answers within the window, else error at s+TMO+2.
   task automatic expect_exec(input logic [3:0] f, input int lat, input int s);
      logic [15:0] r;
      exp_en_q.push_back('{a: m_a, b: m_b, fun: f, cyc: s + 1});
      if (lat >= 1 && lat <= TMO) begin
         r = alu_ref(m_a, m_b, f);
         exp_tx_q.push_back(r[7:0]);
         exp_tx_q.push_back(r[15:8]);
      end else begin
         exp_err_q.push_back(s + TMO + 2);
      end
   endtask

   task automatic op_frame(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] fb, input int lat);
      int s;
      alu_lat = lat;
      m_a = a;
      m_b = b;
      send_byte(CMD_ALU_OP, s);
      send_byte(a, s);
      send_byte(b, s);
      send_byte(fb, s);
      expect_exec(fb[3:0], lat, s);
   endtask

   task automatic nop_frame(input logic [7:0] fb, input int lat);
      int s;
      alu_lat = lat;
      send_byte(CMD_ALU_NOP, s);
      send_byte(fb, s);
      expect_exec(fb[3:0], lat, s);
   endtask

   task automatic bad_header(input logic [7:0] b);
      int s;
      send_byte(b, s);
      exp_err_q.push_back(s + 1);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp_en_q.size() != 0 || exp_tx_q.size() != 0 || exp_err_q.size() != 0 ||
              bus.TX_D_VLD || busy_tx || bus.OUT_VALID) && n < 300) begin
         @(posedge clk);
         n++;
      end
      check("drain_within_budget", (n < 300), 1);
      repeat (2) @(posedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_alu_a"}, bus.ALU_A, 0);
      check({tag, "_alu_b"}, bus.ALU_B, 0);
      check({tag, "_alu_fun"}, bus.ALU_FUN, 0);
      check({tag, "_alu_en"}, bus.ALU_EN, 0);
      check({tag, "_tx_data"}, bus.TX_P_DATA, 0);
      check({tag, "_tx_vld"}, bus.TX_D_VLD, 0);
      check({tag, "_cmd_err"}, bus.CMD_ERR, 0);
   endtask

   // ---------------- Watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- Main sequence ----------------
   logic [7:0] rb;
   int         s_main;
   logic       bp_bad;
   initial begin
      bus.RX_P_DATA = 8'h00;
      bus.RX_D_VLD  = 1'b0;
      bus.ALU_OUT   = 16'h0000;
      bus.OUT_VALID = 1'b0;

      repeat (3) @(posedge clk);
      #1 check_outputs_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Full operation, then operand reuse.
      op_frame(8'h0F, 8'h03, 8'h00, 2);
      wait_done();
      nop_frame(8'h02, 2);
      wait_done();

      // Bad header followed by a normal frame.
      bad_header(8'h55);
      op_frame(8'h20, 8'h05, 8'hF1, 3);
      wait_done();

      // Timeout, then the latest accepted latency (OUT_VALID wins over expiry).
      op_frame(8'h0F, 8'h03, 8'h00, 0);
      wait_done();
      op_frame(8'h81, 8'h7E, 8'h06, TMO);
      wait_done();

      // Back-pressure on entry to SEND_LO.
      busy_bp = 1'b1;
      op_frame(8'h0F, 8'h03, 8'h00, 2);
      repeat (3) @(posedge clk);
      bp_bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.TX_D_VLD) bp_bad = 1'b1;
      end
      check("bp_tx_vld_low", bp_bad, 0);
      @(posedge clk);
      #1 busy_bp = 1'b0;
      wait_done();

      // Reset while in GET_B: outputs clear immediately.
      send_byte(CMD_ALU_OP, s_main);
      send_byte(8'h44, s_main);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_outputs_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      m_a = 8'h00;
      m_b = 8'h00;

      // NOP with reset operands.
      nop_frame(8'hA0, 3);
      wait_done();

      // Stray RX byte during WAIT_RES.
      alu_lat = 6;
      m_a = 8'h0F;
      m_b = 8'h03;
      send_byte(CMD_ALU_OP, s_main);
      send_byte(8'h0F, s_main);
      send_byte(8'h03, s_main);
      send_byte(8'h00, s_main);
      expect_exec(4'h0, 6, s_main);
      send_byte(8'hA5, s_main);
      exp_err_q.push_back(s_main + 1);
      wait_done();

      // Randomized frames.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0: begin
               rb = 8'($urandom_range(0, 255));
               while (rb == CMD_ALU_OP || rb == CMD_ALU_NOP) rb = 8'($urandom_range(0, 255));
               bad_header(rb);
            end
            1: op_frame(8'($urandom), 8'($urandom), 8'($urandom), 0);
            2, 3, 4: nop_frame(8'($urandom), $urandom_range(1, TMO));
            default: op_frame(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, TMO));
         endcase
         wait_done();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command sequencer directly upstream of the ALU and also its result consumer. It parses a byte stream from the UART RX path into ALU operands and a function code, then pulses the ALU Enable. It captures the 16-bit result on OUT_VALID and returns it as two bytes, LSB first, to the UART TX path over a valid/busy handshake.

Parameters:
DATA_WIDTH, 8, operand and byte width
FUN_WIDTH, 4, ALU function code width
CMD_ALU_OP, 8'hCC, frame header for a full operation: header, A, B, FUN
CMD_ALU_NOP, 8'hDD, frame header that reuses the stored A and B: header, FUN
RES_TIMEOUT, 8, maximum cycles from ALU_EN to OUT_VALID before abort

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  RX_P_DATA valid, one-cycle strobe per byte
ALU_A  out  DATA_WIDTH  operand A to ALU
ALU_B  out  DATA_WIDTH  operand B to ALU
ALU_FUN  out  FUN_WIDTH  function code to ALU
ALU_EN  out  1  ALU Enable, one-cycle pulse
ALU_OUT  in  2*DATA_WIDTH  ALU result
OUT_VALID  in  1  ALU result valid
TX_P_DATA  out  DATA_WIDTH  byte to transmitter
TX_D_VLD  out  1  TX_P_DATA valid
TX_BUSY  in  1  transmitter busy / accept indication
CMD_ERR  out  1  one-cycle error pulse

Behaviour:
- Reset and registering: one clock, CLK. RST is asynchronous and active-high. All outputs are registered. While RST is high, every output and the A/B/FUN/result registers are 0, the timer is 0 and the state is IDLE. Reset mid-frame or mid-send aborts immediately, with no partial byte resumed.
- States: IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT_RES, SEND_LO, SEND_HI.
- IDLE, on RX_D_VLD:
  - byte==CMD_ALU_OP -> GET_A.
  - byte==CMD_ALU_NOP -> GET_FUN.
  - any other byte -> CMD_ERR=1 for one cycle; stay in IDLE.
- GET_A / GET_B: on RX_D_VLD, load ALU_A / ALU_B, then advance.
- GET_FUN: on RX_D_VLD, load ALU_FUN from RX_P_DATA[FUN_WIDTH-1:0] (upper bits ignored) -> EXEC.
- EXEC: ALU_EN=1 for exactly this one cycle, so ALU_EN is high the cycle after the FUN byte strobe -> WAIT_RES. ALU_A, ALU_B and ALU_FUN stay stable from load until the next frame reloads them.
- WAIT_RES: the timer counts from 1.
  - OUT_VALID=1 -> capture ALU_OUT; -> SEND_LO.
  - Timer reaching RES_TIMEOUT without OUT_VALID -> CMD_ERR pulse, -> IDLE, no TX.
  - OUT_VALID and timeout in the same cycle: OUT_VALID wins.
- SEND_LO / SEND_HI use the same two-phase handshake:
  - Phase 1: wait until TX_BUSY==0.
  - Phase 2: drive TX_D_VLD=1 with the byte (result[7:0] in SEND_LO, result[15:8] in SEND_HI), held stable until TX_BUSY is sampled 1. The byte is then accepted and TX_D_VLD drops the next cycle.
  - SEND_LO -> SEND_HI; SEND_HI -> IDLE.
  - No timeout on TX back-pressure.
- RX_D_VLD in EXEC, WAIT_RES, SEND_LO or SEND_HI: byte dropped, CMD_ERR pulse, state unaffected.
- CMD_ALU_NOP before any CMD_ALU_OP frame uses the reset operands A=B=0.
- Widths: the result register is 2*DATA_WIDTH. The timer is $clog2(RES_TIMEOUT+1) bits, saturates and clears on leaving WAIT_RES.
- The ALU's own reset is a separate, active-low signal and is not generated here.

Decomposition:
- Shared package: state enumeration, CMD_ALU_OP / CMD_ALU_NOP constants, byte/function width constants.
- One sub-module, alu_res_timer: enable, clear, expired flag, parameterised by RES_TIMEOUT. The FSM, operand registers and TX handshake stay in the top.

Test Plan:
- Full operation: RX CC,0F,03,00; the ALU model returns 0x0012 with OUT_VALID two cycles after ALU_EN; TX_BUSY rises one cycle after TX_D_VLD. -> Required:
  - ALU_A=0x0F, ALU_B=0x03, ALU_FUN=0.
  - ALU_EN high for one cycle, the cycle after the 00 strobe.
  - TX bytes 0x12 then 0x00, no CMD_ERR.
- Operand reuse: following the first test, RX DD,02; the model returns 0x002D. -> Required: ALU_FUN=2, A/B unchanged at 0F/03, TX 0x2D then 0x00.
- Bad header: RX 0x55 in IDLE. -> Required: CMD_ERR for one cycle, no ALU_EN, state remains IDLE; a following CC frame works normally.
- Timeout: full frame sent, OUT_VALID never asserted. -> Required: CMD_ERR pulse at the 8th WAIT_RES cycle after ALU_EN, no TX_D_VLD, return to IDLE.
- Back-pressure: TX_BUSY held 1 for 20 cycles on entry to SEND_LO. -> Required:
  - TX_D_VLD stays 0 until busy drops, then rises with 0x12, held stable until busy is seen.
  - The high byte follows only after busy is low again.
- Reset mid-frame and stray RX: RST pulse while in GET_B. -> Required: all outputs 0 immediately (asynchronous), ALU_A=0. An RX byte during WAIT_RES of a later frame produces a CMD_ERR pulse and the result is still sent correctly.
